psk_demod_slicer: RTL and testbench

- Receive-side counterpart of the PSK modulator.
- Takes coherent, derotated baseband I/Q samples (after carrier mixing), integrates and dumps over each 16-sample symbol, and hard-decides QPSK (2 bit) or BPSK (1 bit) symbols on the modulator's constellation.
- Packs the decided bits into bytes and delivers them on an AXI-Stream master to the frame/byte sink.
- Sits between the receive mixer/loop filter and the deframer.

---
 rtl/psk_pkg.sv | 35 +++
 rtl/psk_demod_slicer_if.sv | 11 +
 rtl/psk_iq_integrator.sv | 76 +++++++
 rtl/psk_demod_slicer.sv | 195 +++++++++++++++++++
 tb/tb_psk_demod_slicer.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/psk_pkg.sv
// Shared PSK constants: symbol timing, constellation codes and the QPSK slicer helper.
package psk_pkg;

  localparam int SPS      = 16;
  localparam int SPS_LOG2 = 4;
  localparam int BYTE_W   = 8;

  // Constellation codes: 00 -> +1, 01 -> +j, 11 -> -1, 10 -> -j
  localparam logic [1:0] SYM_00 = 2'b00;
  localparam logic [1:0] SYM_01 = 2'b01;
  localparam logic [1:0] SYM_11 = 2'b11;
  localparam logic [1:0] SYM_10 = 2'b10;

  localparam int BITS_PER_SYM_QPSK = 2;
  localparam int BITS_PER_SYM_BPSK = 1;

  typedef enum logic {
    MODE_QPSK = 1'b0,
    MODE_BPSK = 1'b1
  } psk_mode_e;

  // Quadrant decision in the 45-degree rotated frame u = I+Q, v = Q-I.
  // Zero counts as non-negative, so the sign bits alone pick the quadrant.
  function automatic logic [1:0] qpsk_decide(input logic u_neg, input logic v_neg);
    logic [1:0] code;
    case ({u_neg, v_neg})
      2'b00:   code = SYM_01;
      2'b01:   code = SYM_00;
      2'b10:   code = SYM_11;
      default: code = SYM_10;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/psk_demod_slicer_if.sv
// Byte stream from the slicer to the deframer (AXI-Stream subset).
interface psk_demod_slicer_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/psk_iq_integrator.sv
// Integrate-and-dump over one symbol: symbol-phase counter, I/Q accumulators,
// window last flag, and the dump strobe with the sums including the current sample.
module psk_iq_integrator
  import psk_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int ACC_W = WIDTH + 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_enable,
  input  logic signed [WIDTH-1:0] in_i,
  input  logic signed [WIDTH-1:0] in_q,
  input  logic                    in_vld,
  input  logic                    in_last,
  input  logic [SPS_LOG2-1:0]     delay_cnt,
  output logic                    dump,
  output logic signed [ACC_W-1:0] sum_i,
  output logic signed [ACC_W-1:0] sum_q,
  output logic                    win_last,
  output logic                    cnt_msb
);

  localparam int EXT_W = ACC_W - WIDTH;

  logic [SPS_LOG2-1:0]     cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_i_q, acc_i_d;
  logic signed [ACC_W-1:0] acc_q_q, acc_q_d;
  logic                    last_q, last_d;
  logic signed [ACC_W-1:0] smp_i_ext, smp_q_ext;

  // Next-state for counter, accumulators and last flag; dump reloads to zero.
  always_comb begin
    smp_i_ext = in_vld ? {{EXT_W{in_i[WIDTH-1]}}, in_i} : '0;
    smp_q_ext = in_vld ? {{EXT_W{in_q[WIDTH-1]}}, in_q} : '0;
    sum_i     = acc_i_q + smp_i_ext;
    sum_q     = acc_q_q + smp_q_ext;
    win_last  = last_q | in_last;
    dump      = clk_enable && (cnt_q == delay_cnt);

    cnt_d   = cnt_q;
    acc_i_d = acc_i_q;
    acc_q_d = acc_q_q;
    last_d  = last_q;
    if (clk_enable) begin
      cnt_d = cnt_q + SPS_LOG2'(1);
      if (dump) begin
        acc_i_d = '0;
        acc_q_d = '0;
        last_d  = 1'b0;
      end else begin
        acc_i_d = sum_i;
        acc_q_d = sum_q;
        last_d  = win_last;
      end
    end
  end

  // Integrator state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      acc_i_q <= '0;
      acc_q_q <= '0;
      last_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_i_q <= acc_i_d;
      acc_q_q <= acc_q_d;
      last_q  <= last_d;
    end
  end

  assign cnt_msb = cnt_q[SPS_LOG2-1];

endmodule

// File: rtl/psk_demod_slicer.sv
// PSK receive slicer: integrate-and-dump, QPSK/BPSK hard decision, MSB-first
// byte packing and a single-entry AXI-Stream output register.
module psk_demod_slicer
  import psk_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int ACC_W = WIDTH + 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_enable,
  input  logic signed [WIDTH-1:0] in_I,
  input  logic signed [WIDTH-1:0] in_Q,
  input  logic                    in_vld,
  input  logic                    in_last,
  input  logic                    in_is_bpsk,
  input  logic [SPS_LOG2-1:0]     DELAY_CNT,
  psk_demod_slicer_if.master      m_axis,
  output logic [1:0]              sym_bits,
  output logic                    sym_vld,
  output logic                    overflow,
  output logic                    out_clk_1M024
);

  localparam logic signed [ACC_W-1:0] ACC_ZERO = '0;

  logic                    dump;
  logic signed [ACC_W-1:0] sum_i, sum_q;
  logic                    win_last;
  logic                    cnt_msb;

  psk_iq_integrator #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_integrator (
    .clk        (clk),
    .rst        (rst),
    .clk_enable (clk_enable),
    .in_i       (in_I),
    .in_q       (in_Q),
    .in_vld     (in_vld),
    .in_last    (in_last),
    .delay_cnt  (DELAY_CNT),
    .dump       (dump),
    .sum_i      (sum_i),
    .sum_q      (sum_q),
    .win_last   (win_last),
    .cnt_msb    (cnt_msb)
  );

  // Slicer / packer state
  logic       sym_vld_q, sym_vld_d;
  logic [1:0] sym_bits_q, sym_bits_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  psk_mode_e  mode_q, mode_d;
  logic       byte_vld_q, byte_vld_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       byte_last_q, byte_last_d;
  logic       byte_user_q, byte_user_d;

  // Output register state
  logic [7:0] tdata_q, tdata_d;
  logic       tvalid_q, tvalid_d;
  logic       tlast_q, tlast_d;
  logic       tuser_q, tuser_d;
  logic       overflow_q, overflow_d;

  // Combinational decision intermediates
  logic                    sym_strobe;
  logic signed [ACC_W-1:0] u, v;
  psk_mode_e               mode_cur;
  logic [1:0]              sym_dec;
  logic [7:0]              shift_ins;
  logic [3:0]              cnt_ins;
  logic                    close_byte;
  logic [7:0]              byte_val;

  // Decide the symbol at the dump edge and shift it into the byte being built.
  always_comb begin
    sym_strobe = dump && in_vld;
    u          = sum_i + sum_q;
    v          = sum_q - sum_i;
    // The first symbol of a byte chooses the mode; later symbols reuse it.
    mode_cur   = (bit_cnt_q == 4'd0) ? psk_mode_e'(in_is_bpsk) : mode_q;

    if (mode_cur == MODE_BPSK) begin
      sym_dec   = {2{sum_i < ACC_ZERO}};
      shift_ins = {shift_q[6:0], sym_dec[0]};
      cnt_ins   = bit_cnt_q + 4'(BITS_PER_SYM_BPSK);
    end else begin
      sym_dec   = qpsk_decide(u < ACC_ZERO, v < ACC_ZERO);
      shift_ins = {shift_q[5:0], sym_dec};
      cnt_ins   = bit_cnt_q + 4'(BITS_PER_SYM_QPSK);
    end

    close_byte = (cnt_ins == 4'(BYTE_W)) || win_last;
    // Left-align a short final byte so the unused LSBs come out as zero.
    byte_val   = shift_ins << (4'(BYTE_W) - cnt_ins);

    sym_vld_d   = sym_strobe;
    sym_bits_d  = sym_bits_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    mode_d      = mode_q;
    byte_vld_d  = 1'b0;
    byte_data_d = byte_data_q;
    byte_last_d = byte_last_q;
    byte_user_d = byte_user_q;

    if (sym_strobe) begin
      sym_bits_d = sym_dec;
      mode_d     = mode_cur;
      if (close_byte) begin
        shift_d     = '0;
        bit_cnt_d   = '0;
        byte_vld_d  = 1'b1;
        byte_data_d = byte_val;
        byte_last_d = win_last;
        byte_user_d = (mode_cur == MODE_BPSK);
      end else begin
        shift_d   = shift_ins;
        bit_cnt_d = cnt_ins;
      end
    end
  end

  // Single-entry output register: hold until accepted, drop new bytes while stalled.
  always_comb begin
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    tuser_d    = tuser_q;
    overflow_d = overflow_q;

    if (tvalid_q && m_axis.tready) begin
      tvalid_d = 1'b0;
    end
    if (byte_vld_q) begin
      if (tvalid_q && !m_axis.tready) begin
        overflow_d = 1'b1;
      end else begin
        tdata_d  = byte_data_q;
        tlast_d  = byte_last_q;
        tuser_d  = byte_user_q;
        tvalid_d = 1'b1;
      end
    end
  end

  // All slicer, packer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_vld_q   <= 1'b0;
      sym_bits_q  <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      mode_q      <= MODE_QPSK;
      byte_vld_q  <= 1'b0;
      byte_data_q <= '0;
      byte_last_q <= 1'b0;
      byte_user_q <= 1'b0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      sym_vld_q   <= sym_vld_d;
      sym_bits_q  <= sym_bits_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      mode_q      <= mode_d;
      byte_vld_q  <= byte_vld_d;
      byte_data_q <= byte_data_d;
      byte_last_q <= byte_last_d;
      byte_user_q <= byte_user_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
      overflow_q  <= overflow_d;
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tuser  = tuser_q;
  assign sym_bits      = sym_bits_q;
  assign sym_vld       = sym_vld_q;
  assign overflow      = overflow_q;
  assign out_clk_1M024 = cnt_msb;

endmodule

// File: tb/tb_psk_demod_slicer.sv
// Randomized + directed bench for psk_demod_slicer against a sample-level
// behavioural model (integer sums, bit queue packing).
module tb_psk_demod_slicer;
  import psk_pkg::*;

  localparam int WIDTH = 12;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    clk_enable;
  logic signed [WIDTH-1:0] in_I, in_Q;
  logic                    in_vld, in_last, in_is_bpsk;
  logic [3:0]              DELAY_CNT;
  logic [1:0]              sym_bits;
  logic                    sym_vld, overflow, out_clk_1M024;

  psk_demod_slicer_if m_axis ();

  psk_demod_slicer #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .clk_enable    (clk_enable),
    .in_I          (in_I),
    .in_Q          (in_Q),
    .in_vld        (in_vld),
    .in_last       (in_last),
    .in_is_bpsk    (in_is_bpsk),
    .DELAY_CNT     (DELAY_CNT),
    .m_axis        (m_axis),
    .sym_bits      (sym_bits),
    .sym_vld       (sym_vld),
    .overflow      (overflow),
    .out_clk_1M024 (out_clk_1M024)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_cnt;
  int         m_acc_i, m_acc_q;
  bit         m_last;
  bit         m_bits[$];
  bit         m_mode;
  logic [1:0] exp_sym[$];
  logic [9:0] exp_byte[$];   // {user, last, data}

  int         rx_count  = 0;
  int         sym_count = 0;
  logic [9:0] last_rx   = '0;
  bit         gaps      = 0;
  bit         rdy_random = 0;
  bit         rdy_force  = 1;

  task automatic model_clear();
    m_cnt = 0; m_acc_i = 0; m_acc_q = 0; m_last = 0; m_mode = 0;
    m_bits.delete(); exp_sym.delete(); exp_byte.delete();
  endtask

  task automatic model_emit(input int s_i, input int s_q, input bit bpsk, input bit wl);
    logic [1:0] sym;
    logic [7:0] b;
    if (m_bits.size() == 0) m_mode = bpsk;
    if (m_mode) begin
      sym = {2{s_i < 0}};
      m_bits.push_back(sym[0]);
    end else begin
      sym = {(s_i + s_q) < 0, (s_q - s_i) >= 0};
      m_bits.push_back(sym[1]);
      m_bits.push_back(sym[0]);
    end
    exp_sym.push_back(sym);
    if (m_bits.size() >= 8 || wl) begin
      b = '0;
      for (int i = 0; i < 8; i++) b = {b[6:0], (i < m_bits.size()) ? m_bits[i] : 1'b0};
      exp_byte.push_back({m_mode, wl, b});
      m_bits.delete();
    end
  endtask

  // One enabled sample as the specification describes it.
  task automatic model_sample(input int si, input int sq, input bit vld, input bit last, input bit bpsk);
    int vi, vq;
    vi = vld ? si : 0;
    vq = vld ? sq : 0;
    if (m_cnt == int'(DELAY_CNT)) begin
      if (vld) model_emit(m_acc_i + vi, m_acc_q + vq, bpsk, m_last | last);
      m_acc_i = 0; m_acc_q = 0; m_last = 0;
    end else begin
      m_acc_i += vi; m_acc_q += vq; m_last |= last;
    end
    m_cnt = (m_cnt + 1) % SPS;
  endtask

  // ---------------- drivers ----------------
  task automatic drive_sample(input int si, input int sq, input bit vld, input bit last, input bit bpsk);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        clk_enable = 1'b0;
        in_I = 12'($urandom); in_Q = 12'($urandom);
        in_vld = 1'($urandom); in_last = 1'($urandom); in_is_bpsk = 1'($urandom);
        @(posedge clk); #1;
      end
    end
    clk_enable = 1'b1;
    in_I = 12'(si); in_Q = 12'(sq);
    in_vld = vld; in_last = last; in_is_bpsk = bpsk;
    model_sample(si, sq, vld, last, bpsk);
    @(posedge clk); #1;
    clk_enable = 1'b0;
  endtask

  task automatic send_symbol(input int i0, input int q0, input bit bpsk, input bit last, input int noise);
    int ni, nq;
    for (int k = 0; k < SPS; k++) begin
      ni = (noise > 0) ? int'($urandom_range(0, 2 * noise)) - noise : 0;
      nq = (noise > 0) ? int'($urandom_range(0, 2 * noise)) - noise : 0;
      drive_sample(i0 + ni, q0 + nq, 1'b1, last && (k == 7), bpsk);
    end
  endtask

  task automatic send_random_symbol();
    bit bpsk, lst, vld;
    int lastk;
    bpsk  = 1'($urandom);
    lst   = ($urandom_range(0, 7) == 0);
    lastk = $urandom_range(0, 15);
    for (int k = 0; k < SPS; k++) begin
      vld = (k == SPS - 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 7) != 0);
      drive_sample(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
                   vld, lst && (k == lastk), bpsk);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_rx(input int target, input int budget);
    int n = 0;
    while (rx_count < target && n < budget) begin @(posedge clk); #1; n++; end
    if (rx_count < target) chk("rx_timeout", 32'(rx_count), 32'(target));
  endtask

  task automatic do_reset();
    rst = 1'b1; clk_enable = 1'b0;
    in_I = '0; in_Q = '0; in_vld = 1'b0; in_last = 1'b0; in_is_bpsk = 1'b0;
    @(posedge clk); #1;
    model_clear();
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_tvalid"},   32'(m_axis.tvalid), 32'd0);
    chk({pfx, "_tdata"},    32'(m_axis.tdata),  32'd0);
    chk({pfx, "_tlast"},    32'(m_axis.tlast),  32'd0);
    chk({pfx, "_tuser"},    32'(m_axis.tuser),  32'd0);
    chk({pfx, "_sym_vld"},  32'(sym_vld),       32'd0);
    chk({pfx, "_sym_bits"}, 32'(sym_bits),      32'd0);
    chk({pfx, "_overflow"}, 32'(overflow),      32'd0);
    chk({pfx, "_symclk"},   32'(out_clk_1M024), 32'd0);
  endtask

  // Sink ready: random or forced, changed just after each rising edge.
  initial m_axis.tready = 1'b1;
  always @(posedge clk) begin
    #1;
    m_axis.tready = rdy_random ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  // Scoreboard: every symbol pulse and every accepted byte against the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (sym_vld) begin
        if (exp_sym.size() == 0) chk("sym_extra", 32'(sym_vld), 32'd0);
        else chk("sym_bits", 32'(sym_bits), 32'(exp_sym.pop_front()));
        sym_count++;
      end
      if (m_axis.tvalid && m_axis.tready) begin
        last_rx = {m_axis.tuser, m_axis.tlast, m_axis.tdata};
        if (exp_byte.size() == 0) chk("byte_extra", 32'(m_axis.tvalid), 32'd0);
        else chk("byte", 32'(last_rx), 32'(exp_byte.pop_front()));
        rx_count++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got=running expected=done");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_rx, base_sym;
    int signs[8] = '{1, -1, -1, 1, 1, 1, -1, 1};

    DELAY_CNT = 4'd15;
    do_reset();
    chk_all_zero("reset");

    // QPSK +1, +j, -1, -j -> 00 01 11 10 = 0x1E
    base_rx = rx_count;
    send_symbol(1000, 0, 0, 0, 0);
    send_symbol(0, 1000, 0, 0, 0);
    send_symbol(-1000, 0, 0, 0, 0);
    send_symbol(0, -1000, 0, 0, 0);
    wait_rx(base_rx + 1, 20);
    chk("qpsk_byte", 32'(last_rx), 32'h01E);

    // BPSK + - - + + + - + -> 0x62, tuser=1
    base_rx = rx_count;
    for (int s = 0; s < 8; s++) send_symbol(signs[s] * 800, 0, 1, 0, 100);
    wait_rx(base_rx + 1, 20);
    chk("bpsk_byte", 32'(last_rx), 32'h262);

    // Early close: +j, +1, -1(last) -> 0x4C with tlast, then a fresh byte -1,-j,+1,+j -> 0xE1
    base_rx = rx_count;
    send_symbol(0, 900, 0, 0, 50);
    send_symbol(900, 0, 0, 0, 50);
    send_symbol(-900, 0, 0, 1, 50);
    wait_rx(base_rx + 1, 20);
    chk("last_byte", 32'(last_rx), 32'h14C);
    send_symbol(-900, 0, 0, 0, 50);
    send_symbol(0, -900, 0, 0, 50);
    send_symbol(900, 0, 0, 0, 50);
    send_symbol(0, 900, 0, 0, 50);
    wait_rx(base_rx + 2, 20);
    chk("after_last", 32'(last_rx), 32'h0E1);

    // Randomized: full-scale samples, enable gaps, invalid samples, mode changes, random ready
    gaps = 1; rdy_random = 1;
    for (int s = 0; s < 60; s++) send_random_symbol();
    gaps = 0; rdy_random = 0; rdy_force = 1;
    wait_clks(20);
    chk("rand_drain", 32'(exp_byte.size()), 32'd0);
    chk("rand_sym_drain", 32'(exp_sym.size()), 32'd0);
    chk("rand_overflow", 32'(overflow), 32'd0);

    // Backpressure: 0x1E held, 0xFF dropped, overflow set, then exactly one transfer
    do_reset();
    rdy_force = 0;
    wait_clks(2);
    base_rx = rx_count;
    send_symbol(1000, 0, 0, 0, 0);
    send_symbol(0, 1000, 0, 0, 0);
    send_symbol(-1000, 0, 0, 0, 0);
    send_symbol(0, -1000, 0, 0, 0);
    wait_clks(3);
    chk("bp_hold_tvalid", 32'(m_axis.tvalid), 32'd1);
    chk("bp_hold_tdata", 32'(m_axis.tdata), 32'h1E);
    for (int s = 0; s < 4; s++) send_symbol(-1000, 0, 0, 0, 0);
    wait_clks(3);
    chk("bp_overflow", 32'(overflow), 32'd1);
    chk("bp_stable_tdata", 32'(m_axis.tdata), 32'h1E);
    if (exp_byte.size() > 0) void'(exp_byte.pop_back());
    rdy_force = 1;
    wait_rx(base_rx + 1, 10);
    wait_clks(5);
    chk("bp_one_xfer", 32'(rx_count), 32'(base_rx + 1));
    chk("bp_tvalid_low", 32'(m_axis.tvalid), 32'd0);
    chk("bp_xfer_data", 32'(last_rx), 32'h01E);

    // DELAY_CNT=5: first dump has in_vld low -> no symbol; next window starts from zero
    do_reset();
    DELAY_CNT = 4'd5;
    base_sym = sym_count;
    for (int k = 0; k < 6; k++) drive_sample(1000, 0, (k != 5), 1'b0, 1'b0);
    wait_clks(3);
    chk("d5_no_sym", 32'(sym_count), 32'(base_sym));
    base_rx = rx_count;
    send_symbol(-300, 0, 0, 0, 0);
    wait_clks(2);
    chk("d5_sym", 32'(sym_bits), 32'(SYM_11));
    send_symbol(1000, 0, 0, 0, 0);
    send_symbol(0, 1000, 0, 0, 0);
    send_symbol(0, -1000, 0, 0, 0);
    wait_rx(base_rx + 1, 20);
    chk("d5_byte", 32'(last_rx), 32'h0C6);

    // Reset mid-byte while a byte is pending, then a clean byte
    DELAY_CNT = 4'd15;
    do_reset();
    rdy_force = 0;
    wait_clks(2);
    send_symbol(1000, 0, 0, 0, 0);
    send_symbol(1000, 0, 0, 0, 0);
    send_symbol(1000, 0, 0, 0, 0);
    send_symbol(1000, 0, 0, 0, 0);
    send_symbol(0, 1000, 0, 0, 0);
    send_symbol(0, 1000, 0, 0, 0);
    chk("rst_pre_tvalid", 32'(m_axis.tvalid), 32'd1);
    base_rx = rx_count;
    do_reset();
    chk_all_zero("midrst");
    rdy_force = 1;
    send_symbol(0, -1000, 0, 0, 0);
    send_symbol(-1000, 0, 0, 0, 0);
    send_symbol(0, 1000, 0, 0, 0);
    send_symbol(1000, 0, 0, 0, 0);
    wait_rx(base_rx + 1, 20);
    wait_clks(3);
    chk("post_rst_byte", 32'(last_rx), 32'h0B4);
    chk("post_rst_count", 32'(rx_count), 32'(base_rx + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
